// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between two masters.
// One transfer in flight: IDLE -> ACCESS -> DONE, with stall timeout abort.
module mem_bus_arbiter #(
  parameter bit FIXED_PRIO   = 1'b0,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [23:0] p0_addr,
  input  logic [15:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [23:0] p1_addr,
  input  logic [15:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [15:0] rdata_o,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic [23:0] addr_o,
  output logic        re_o,
  output logic        we_o,
  inout  wire  [15:0] data_io,
  input  logic        needWait_i
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_TIMEOUT);
  localparam logic [CW-1:0] CNT_TMO = CW'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t        state_q;
  logic          last_q;
  logic          we_q;
  logic [15:0]   wdata_q;
  logic [CW-1:0] cnt_q;

  logic          win1_d;
  logic          we_d;
  logic [23:0]   addr_d;
  logic [15:0]   wdata_d;

  // last_q names the port granted most recently; a tie goes to the other one
  always_comb begin
    win1_d = 1'b0;
    if (p1_req && !p0_req) begin
      win1_d = 1'b1;
    end else if (p0_req && p1_req) begin
      win1_d = FIXED_PRIO ? 1'b0 : ~last_q;
    end
    we_d    = win1_d ? p1_we    : p0_we;
    addr_d  = win1_d ? p1_addr  : p0_addr;
    wdata_d = win1_d ? p1_wdata : p0_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
      grant_o <= '0;
      addr_o  <= '0;
      re_o    <= 1'b0;
      we_o    <= 1'b0;
      rdata_o <= '0;
      p0_ack  <= 1'b0;
      p0_err  <= 1'b0;
      p1_ack  <= 1'b0;
      p1_err  <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            state_q <= S_ACCESS;
            grant_o <= win1_d ? 2'b10 : 2'b01;
            last_q  <= win1_d;
            we_q    <= we_d;
            addr_o  <= addr_d;
            wdata_q <= wdata_d;
            re_o    <= ~we_d;
            we_o    <= we_d;
            cnt_q   <= '0;
          end
        end
        S_ACCESS: begin
          if (!needWait_i) begin
            if (!we_q) rdata_o <= data_io;
            state_q <= S_DONE;
            re_o    <= 1'b0;
            we_o    <= 1'b0;
            p0_ack  <= grant_o[0];
            p1_ack  <= grant_o[1];
          end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_TMO) begin
              state_q <= S_DONE;
              re_o    <= 1'b0;
              we_o    <= 1'b0;
              p0_err  <= grant_o[0];
              p1_err  <= grant_o[1];
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          grant_o <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign data_io = we_o ? wdata_q : 16'bz;

endmodule
